// File: rtl/commit_trace_buf.sv
// Retire-side commit buffer: a small FIFO between writeback and the commit reporter,
// with a retired-instruction counter, a PC-chain continuity check and a no-commit watchdog.
module commit_trace_buf #(
    parameter int DEPTH   = 4,
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_nextpc,
    input  logic [XLEN-1:0] in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_nextpc,
    output logic [XLEN-1:0] out_inst,
    output logic [63:0]     commit_cnt,
    output logic            pc_mismatch,
    output logic [XLEN-1:0] mismatch_pc,
    output logic            hang
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] IDLE_MAX = CW'(TIMEOUT);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] nextpc;
        logic [XLEN-1:0] inst;
    } rec_t;

    rec_t            r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_count;
    logic [63:0]     r_commit_cnt;
    logic            r_have_last;
    logic [XLEN-1:0] r_last_nextpc;
    logic            r_mismatch;
    logic [XLEN-1:0] r_mismatch_pc;
    logic [CW-1:0]   r_idle;
    logic            r_hang;

    logic            w_push;
    logic            w_pop;
    rec_t            w_head;
    logic [CW-1:0]   w_idle_nxt;

    // Readiness depends only on the registered count, so a full buffer never
    // looks at out_ready: a pop and a push cannot share a full cycle.
    assign in_ready  = (r_count != CNT_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_head    = r_mem[r_rd_ptr];

    assign out_pc      = w_head.pc;
    assign out_nextpc  = w_head.nextpc;
    assign out_inst    = w_head.inst;
    assign commit_cnt  = r_commit_cnt;
    assign pc_mismatch = r_mismatch;
    assign mismatch_pc = r_mismatch_pc;
    assign hang        = r_hang;

    always_ff @(posedge clock) begin
        if (reset && w_push) r_mem[r_wr_ptr] <= {in_pc, in_nextpc, in_inst};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Only the first break is recorded; later ones leave mismatch_pc alone.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_commit_cnt  <= '0;
            r_have_last   <= 1'b0;
            r_last_nextpc <= '0;
            r_mismatch    <= 1'b0;
            r_mismatch_pc <= '0;
        end else if (w_pop) begin
            r_commit_cnt <= r_commit_cnt + 64'd1;
            if (r_have_last && (w_head.pc != r_last_nextpc) && !r_mismatch) begin
                r_mismatch    <= 1'b1;
                r_mismatch_pc <= w_head.pc;
            end
            r_last_nextpc <= w_head.nextpc;
            r_have_last   <= 1'b1;
        end
    end

    always_comb begin
        w_idle_nxt = r_idle;
        if (w_pop)                  w_idle_nxt = '0;
        else if (r_idle != IDLE_MAX) w_idle_nxt = r_idle + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_idle <= '0;
            r_hang <= 1'b0;
        end else begin
            r_idle <= w_idle_nxt;
            r_hang <= r_hang | (w_idle_nxt == IDLE_MAX);
        end
    end
endmodule

// File: tb/tb_commit_trace_buf.sv
// Scoreboard bench for commit_trace_buf: a queue models the FIFO contents and
// small model registers track the counter, PC-chain check and watchdog.
module tb_commit_trace_buf;
    localparam int DEPTH   = 4;
    localparam int XLEN    = 32;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] inst;
    } rec_t;

    logic            clock, reset;
    logic            in_valid, in_ready, out_valid, out_ready;
    logic [XLEN-1:0] in_pc, in_nextpc, in_inst;
    logic [XLEN-1:0] out_pc, out_nextpc, out_inst;
    logic [63:0]     commit_cnt;
    logic            pc_mismatch, hang;
    logic [XLEN-1:0] mismatch_pc;

    commit_trace_buf #(.DEPTH(DEPTH), .XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_nextpc(in_nextpc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_nextpc(out_nextpc), .out_inst(out_inst),
        .commit_cnt(commit_cnt), .pc_mismatch(pc_mismatch),
        .mismatch_pc(mismatch_pc), .hang(hang)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    rec_t        q[$];
    logic [63:0] m_cnt;
    bit          m_have, m_mis, m_hang;
    logic [31:0] m_last, m_mis_pc;
    int          m_idle;

    // Drive one cycle (called just after a rising edge), compare the DUT against
    // the model at the falling edge, then advance the model across the next edge.
    task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] npc,
                        input logic [31:0] inst, input bit ordy, output bit pushed);
        bit push, pop;
        rec_t h;
        logic [1:0] exp_hs;
        in_valid  = v;
        in_pc     = pc;
        in_nextpc = npc;
        in_inst   = inst;
        out_ready = ordy;
        @(negedge clock);
        exp_hs = {q.size() != DEPTH, q.size() != 0};
        n_chk++;
        if ({in_ready, out_valid} !== exp_hs)
            $display("FAIL handshake: got ready/valid=%b want %b", {in_ready, out_valid}, exp_hs);
        else n_pass++;
        if (q.size() != 0) begin
            n_chk++;
            if ({out_pc, out_nextpc, out_inst} !== {q[0].pc, q[0].npc, q[0].inst})
                $display("FAIL head: got %h/%h/%h want %h/%h/%h", out_pc, out_nextpc, out_inst,
                         q[0].pc, q[0].npc, q[0].inst);
            else n_pass++;
        end
        n_chk++;
        if (commit_cnt !== m_cnt) $display("FAIL commit_cnt: got %0d want %0d", commit_cnt, m_cnt);
        else n_pass++;
        n_chk++;
        if ({pc_mismatch, hang, mismatch_pc} !== {m_mis, m_hang, m_mis_pc})
            $display("FAIL status: got mis=%b hang=%b mpc=%h want mis=%b hang=%b mpc=%h",
                     pc_mismatch, hang, mismatch_pc, m_mis, m_hang, m_mis_pc);
        else n_pass++;
        push = v && (q.size() != DEPTH);
        pop  = ordy && (q.size() != 0);
        @(posedge clock);
        #1;
        if (pop) begin
            h = q.pop_front();
            if (m_have && h.pc != m_last && !m_mis) begin
                m_mis    = 1'b1;
                m_mis_pc = h.pc;
            end
            m_last = h.npc;
            m_have = 1'b1;
            m_cnt  = m_cnt + 64'd1;
            m_idle = 0;
        end else if (m_idle < TIMEOUT) m_idle++;
        if (m_idle == TIMEOUT) m_hang = 1'b1;
        if (push) q.push_back('{pc, npc, inst});
        pushed = push;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'hdead_beef;
        in_nextpc = 32'hdead_bef3;
        in_inst   = 32'h0000_0013;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        q.delete();
        m_cnt = '0; m_have = 0; m_mis = 0; m_hang = 0;
        m_last = '0; m_mis_pc = '0; m_idle = 0;
    endtask

    task automatic test_reset();
        bit p;
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h1234_0000;
        in_nextpc = 32'h1234_0004;
        in_inst   = 32'h0000_0013;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_chk++;
        if ({out_valid, in_ready, pc_mismatch, hang} !== 4'b0100)
            $display("FAIL reset_flags: got v/r/mis/hang=%b want 0100",
                     {out_valid, in_ready, pc_mismatch, hang});
        else n_pass++;
        n_chk++;
        if (commit_cnt !== 64'd0) $display("FAIL reset_cnt: got %0d want 0", commit_cnt);
        else n_pass++;
        @(posedge clock);
        #1;
        reset = 1'b1;
        in_valid = 1'b0;
        q.delete();
        m_cnt = '0; m_have = 0; m_mis = 0; m_hang = 0;
        m_last = '0; m_mis_pc = '0; m_idle = 0;
        step(1, 32'h8000_0000, 32'h8000_0004, 32'h0000_0413, 0, p);
        n_chk++;
        if (out_valid !== 1'b1) $display("FAIL first_latency: got out_valid=%b want 1", out_valid);
        else n_pass++;
        step(0, '0, '0, '0, 1, p);
    endtask

    task automatic test_single_commit();
        bit p;
        do_reset();
        step(1, 32'h8000_0000, 32'h8000_0004, 32'h0000_0413, 1, p);
        step(0, '0, '0, '0, 1, p);
        n_chk++;
        if (commit_cnt !== 64'd1) $display("FAIL single_cnt: got %0d want 1", commit_cnt);
        else n_pass++;
        step(0, '0, '0, '0, 1, p);
        n_chk++;
        if (out_valid !== 1'b0) $display("FAIL single_empty: got out_valid=%b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit p;
        logic [31:0] pc;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pc = 32'h8000_0000 + 32'(4 * i);
            step(1, pc, pc + 32'd4, 32'h0000_0413 + 32'(i), 0, p);
        end
        n_chk++;
        if (in_ready !== 1'b0) $display("FAIL full_ready: got in_ready=%b want 0", in_ready);
        else n_pass++;
        pc = 32'h8000_0010;
        // Full with a concurrent pop: the held record is refused this cycle.
        step(1, pc, pc + 32'd4, 32'h0000_0417, 1, p);
        step(1, pc, pc + 32'd4, 32'h0000_0417, 1, p);
        for (int i = 0; i < 6; i++) step(0, '0, '0, '0, 1, p);
        n_chk++;
        if ({out_valid, commit_cnt} !== {1'b0, 64'd5})
            $display("FAIL drain: got valid=%b cnt=%0d want 0/5", out_valid, commit_cnt);
        else n_pass++;
        n_chk++;
        if (pc_mismatch !== 1'b0) $display("FAIL seq_chain: got pc_mismatch=%b want 0", pc_mismatch);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit p;
        logic [31:0] pc;
        do_reset();
        step(1, 32'h1000, 32'h1004, 32'h13, 0, p);
        for (int i = 1; i < 8; i++) begin
            pc = 32'h1000 + 32'(4 * i);
            step(1, pc, pc + 32'd4, 32'h13 + 32'(i), 1, p);
            n_chk++;
            if ({out_valid, in_ready} !== 2'b11)
                $display("FAIL stream_%0d: got valid/ready=%b want 11", i, {out_valid, in_ready});
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) step(0, '0, '0, '0, 1, p);
        n_chk++;
        if (commit_cnt !== 64'd8) $display("FAIL stream_cnt: got %0d want 8", commit_cnt);
        else n_pass++;
    endtask

    task automatic test_pc_chain();
        bit p;
        logic [31:0] pcs [4] = '{32'h100, 32'h104, 32'h200, 32'h300};
        do_reset();
        for (int i = 0; i < 4; i++) step(1, pcs[i], pcs[i] + 32'd4, 32'h13, 1, p);
        for (int i = 0; i < 2; i++) step(0, '0, '0, '0, 1, p);
        n_chk++;
        if ({pc_mismatch, mismatch_pc} !== {1'b1, 32'h200})
            $display("FAIL pc_chain: got mis=%b mpc=%h want 1/00000200", pc_mismatch, mismatch_pc);
        else n_pass++;
    endtask

    task automatic test_watchdog();
        bit p;
        do_reset();
        for (int i = 0; i < 15; i++) step(0, '0, '0, '0, 0, p);
        n_chk++;
        if (hang !== 1'b0) $display("FAIL hang_early: got %b want 0", hang);
        else n_pass++;
        step(0, '0, '0, '0, 0, p);
        n_chk++;
        if (hang !== 1'b1) $display("FAIL hang_set: got %b want 1", hang);
        else n_pass++;
        step(1, 32'h40, 32'h44, 32'h13, 1, p);
        step(0, '0, '0, '0, 1, p);
        step(0, '0, '0, '0, 1, p);
        n_chk++;
        if ({hang, commit_cnt} !== {1'b1, 64'd1})
            $display("FAIL hang_sticky: got hang=%b cnt=%0d want 1/1", hang, commit_cnt);
        else n_pass++;
        do_reset();
        step(0, '0, '0, '0, 0, p);
        n_chk++;
        if (hang !== 1'b0) $display("FAIL hang_reset: got %b want 0", hang);
        else n_pass++;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_nextpc = '0;
        in_inst   = '0;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        test_reset();
        test_single_commit();
        test_backpressure();
        test_back_to_back();
        test_pc_chain();
        test_watchdog();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
